alu_mul_seq: RTL

Multi-cycle multiplier that sequences the shared 16-bit Hack `alu` (`zx,nx,zy,ny,f,no` control) through a shift-and-add loop to produce the low 16 bits of `a*b`. It sits beside the CPU datapath as a coprocessor and uses valid/ready handshakes on both sides. All additions go through the single `alu` instance, so this block is purely a controller and register file around it. The result is identical for signed and unsigned operands, since it is two's complement modulo 2^16.

---
 rtl/hack_alu_pkg.sv | 33 +++
 rtl/alu.sv | 34 +++
 rtl/alu_mul_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/hack_alu_pkg.sv
// Shared Hack ALU control codes and the multiplier FSM state type.
package hack_alu_pkg;

  localparam int unsigned ALU_W      = 16;
  localparam int unsigned ALU_CTRL_W = 6;

  // Control order is {zx, nx, zy, ny, f, no}.
  localparam logic [ALU_CTRL_W-1:0] ALU_ZERO        = 6'b101010;
  localparam logic [ALU_CTRL_W-1:0] ALU_ONE         = 6'b111111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NEG_ONE     = 6'b111010;
  localparam logic [ALU_CTRL_W-1:0] ALU_X           = 6'b001100;
  localparam logic [ALU_CTRL_W-1:0] ALU_Y           = 6'b110000;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOT_X       = 6'b001101;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOT_Y       = 6'b110001;
  localparam logic [ALU_CTRL_W-1:0] ALU_NEG_X       = 6'b001111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NEG_Y       = 6'b110011;
  localparam logic [ALU_CTRL_W-1:0] ALU_X_PLUS_1    = 6'b011111;
  localparam logic [ALU_CTRL_W-1:0] ALU_Y_PLUS_1    = 6'b110111;
  localparam logic [ALU_CTRL_W-1:0] ALU_X_MINUS_1   = 6'b001110;
  localparam logic [ALU_CTRL_W-1:0] ALU_Y_MINUS_1   = 6'b110010;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD         = 6'b000010;
  localparam logic [ALU_CTRL_W-1:0] ALU_X_MINUS_Y   = 6'b010011;
  localparam logic [ALU_CTRL_W-1:0] ALU_Y_MINUS_X   = 6'b000111;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND         = 6'b000000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR          = 6'b010101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit Hack ALU.
module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] fxy;

  // Operand preconditioning, function select and output negation.
  always_comb begin
    xs  = zx ? '0 : x;
    xs  = nx ? ~xs : xs;
    ys  = zy ? '0 : y;
    ys  = ny ? ~ys : ys;
    fxy = f ? WIDTH'(xs + ys) : (xs & ys);
    out = no ? ~fxy : fxy;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencing the shared Hack ALU; low WIDTH bits of a*b.
import hack_alu_pkg::*;

module alu_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  mul_state_t state;
  mul_state_t next_state;

  logic [WIDTH-1:0]      acc;
  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      mplier;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]      alu_out;
  logic                  alu_zr;
  logic                  alu_ng;
  logic                  unused_alu_flags;

  // Single shared adder: acc + mcand while running, constant zero otherwise.
  alu #(.WIDTH(WIDTH)) u_alu (
    .x  (acc),
    .y  (mcand),
    .zx (alu_ctrl[5]),
    .nx (alu_ctrl[4]),
    .zy (alu_ctrl[3]),
    .ny (alu_ctrl[2]),
    .f  (alu_ctrl[1]),
    .no (alu_ctrl[0]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  // Flags are taken from acc itself, not from the ALU output.
  assign unused_alu_flags = alu_zr ^ alu_ng;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: loop until the multiplier is exhausted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (mplier == '0) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded handshake outputs and ALU control.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    alu_ctrl  = ALU_ZERO;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        busy     = 1'b1;
        alu_ctrl = ALU_ADD;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand load on accept, then one shift-and-add step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
          end
        end
        RUN: begin
          if (mplier != '0) begin
            if (mplier[0]) acc <= alu_out;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign result = acc;
  assign zr     = (acc == '0);
  assign ng     = acc[WIDTH-1];

endmodule
